// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port RAM between two requesters. Port 0 is instruction
//   fetch and port 1 is the load/store unit. When both request at once, the
//   port that was not served last wins. Each access is run as a short fixed
//   sequence. A write takes IDLE then WR. A read takes IDLE, RD1 and RD2, and
//   returns the data on pN_rdata with a one-cycle pN_rvalid strobe.
//   Every output comes straight from a register.
//
// Ports
//   clock, reset_n            single clock; synchronous active-low reset
//   pN_req/write/addr/wdata   request from port N (held until granted)
//   pN_gnt                    one-cycle grant pulse to port N
//   pN_rvalid/pN_rdata        read return to port N; rdata holds between strobes
//   ram_address/write/data    registered command to the RAM
//   ram_out                   registered read data from the RAM (1-cycle latency)
module ram_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  p0_req,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // port served most recently
  logic                  owner_q, owner_d;            // port owning the current access
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic                  ram_write_q, ram_write_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;

  logic                  win;        // port that wins an IDLE decision
  logic                  win_write;  // the winner's write/read flag

  always_comb begin
    // NOTE: every signal gets a default before the case statement. Without
    // this, a path that does not assign a signal would infer a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    gnt_d         = 2'b00;
    rvalid_d      = 2'b00;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_write_d   = 1'b0;

    // Contention goes to the port that was not served last. A lone
    // requester always wins.
    win       = (p0_req && p1_req) ? ~last_grant_q : p1_req;
    win_write = win ? p1_write : p0_write;

    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          owner_d       = win;
          last_grant_d  = win;
          gnt_d[win]    = 1'b1;
          ram_address_d = win ? p1_addr  : p0_addr;
          ram_data_d    = win ? p1_wdata : p0_wdata;
          ram_write_d   = win_write;
          state_d       = win_write ? WR : RD1;
        end
      end
      // The RAM commits the write at the edge that leaves WR.
      WR:  state_d = IDLE;
      // The address is held steady through RD1, so the RAM output is valid in RD2.
      RD1: state_d = RD2;
      RD2: begin
        rvalid_d[owner_q] = 1'b1;
        if (owner_q) p1_rdata_d = ram_out;
        else         p0_rdata_d = ram_out;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, whatever order the statements are in.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      gnt_q         <= 2'b00;
      rvalid_q      <= 2'b00;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
      ram_address_q <= '0;
      ram_write_q   <= 1'b0;
      ram_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
      ram_address_q <= ram_address_d;
      ram_write_q   <= ram_write_d;
      ram_data_q    <= ram_data_d;
    end
  end

  assign p0_gnt      = gnt_q[0];
  assign p1_gnt      = gnt_q[1];
  assign p0_rvalid   = rvalid_q[0];
  assign p1_rvalid   = rvalid_q[1];
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;
  assign ram_address = ram_address_q;
  assign ram_write   = ram_write_q;
  assign ram_data    = ram_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Randomised, scoreboard-checked bench for ram_arbiter with a behavioural
//   RAM attached. A transaction-level reference model predicts three things:
//   the grant order, the RAM writes and the read data. The monitor compares
//   these with what the DUT presents.
module tb_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          p0_req = 1'b0, p0_write = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_gnt, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_write = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic [AW-1:0] ram_address;
  logic          ram_write;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_out;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_address(ram_address), .ram_write(ram_write), .ram_data(ram_data),
    .ram_out(ram_out)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM: write on the edge, registered read.
  logic [DW-1:0] mem [0:511];
  always @(posedge clock) begin
    ram_out <= mem[ram_address];
    if (ram_write) mem[ram_address] = ram_data;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:511];
  bit            ref_last = 1'b1;
  typedef struct packed { bit port; bit wr; } gnt_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  gnt_t          gnt_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] rd_q0[$], rd_q1[$];
  logic [DW-1:0] exp_rdata0 = '0, exp_rdata1 = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor / scoreboard
  int   cyc = 0;
  int   gnt_cyc0 = 0, gnt_cyc1 = 0;
  gnt_t m_g;
  wr_t  m_w;
  logic [DW-1:0] m_e;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset_n) begin
      if (p0_gnt || p1_gnt) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", {30'd0, p1_gnt, p0_gnt}, 0);
        else begin
          m_g = gnt_q.pop_front();
          check("gnt_port", {30'd0, p1_gnt, p0_gnt}, m_g.port ? 2 : 1);
          check("gnt_write_strobe", {31'd0, ram_write}, {31'd0, m_g.wr});
          if (m_g.port) gnt_cyc1 = cyc; else gnt_cyc0 = cyc;
        end
      end
      if (ram_write) begin
        if (wr_q.size() == 0) check("write_unexpected", {31'd0, ram_write}, 0);
        else begin
          m_w = wr_q.pop_front();
          check("write_addr", {23'd0, ram_address}, {23'd0, m_w.a});
          check("write_data", ram_data, m_w.d);
        end
      end
      if (p0_rvalid || p1_rvalid) begin
        check("rvalid_onehot", {31'd0, p0_rvalid & p1_rvalid}, 0);
        if (p0_rvalid) begin
          if (rd_q0.size() == 0) check("p0_rvalid_unexpected", {31'd0, p0_rvalid}, 0);
          else begin
            m_e = rd_q0.pop_front();
            exp_rdata0 = m_e;
            check("p0_rdata", p0_rdata, m_e);
            check("p0_read_latency", cyc - gnt_cyc0, 2);
            check("p1_rdata_hold", p1_rdata, exp_rdata1);
          end
        end
        if (p1_rvalid) begin
          if (rd_q1.size() == 0) check("p1_rvalid_unexpected", {31'd0, p1_rvalid}, 0);
          else begin
            m_e = rd_q1.pop_front();
            exp_rdata1 = m_e;
            check("p1_rdata", p1_rdata, m_e);
            check("p1_read_latency", cyc - gnt_cyc1, 2);
            check("p0_rdata_hold", p0_rdata, exp_rdata0);
          end
        end
      end
    end
  end

  // Reference model: a single access served for port p, in service order.
  task automatic model_access(input bit p, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    gnt_t g;
    wr_t  x;
    g.port = p;
    g.wr   = w;
    gnt_q.push_back(g);
    if (w) begin
      ref_mem[a] = d;
      x.a = a;
      x.d = d;
      wr_q.push_back(x);
    end else if (p) rd_q1.push_back(ref_mem[a]);
    else            rd_q0.push_back(ref_mem[a]);
  endtask

  function automatic int pending();
    return gnt_q.size() + wr_q.size() + rd_q0.size() + rd_q1.size();
  endfunction

  // One round: the selected ports raise req at the same edge and each is
  // served to completion.
  task automatic do_round(input bit r0, input bit r1, input bit w0, input bit w1,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bit first, done0, done1, drop0, drop1;
    first = (r0 && r1) ? ~ref_last : r1;
    if (!first) begin
      model_access(1'b0, w0, a0, d0);
      if (r1) model_access(1'b1, w1, a1, d1);
      ref_last = r1;
    end else begin
      model_access(1'b1, w1, a1, d1);
      if (r0) model_access(1'b0, w0, a0, d0);
      ref_last = ~r0;
    end
    @(posedge clock); #1;
    p0_req = r0; p0_write = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_write = w1; p1_addr = a1; p1_wdata = d1;
    done0 = !r0; done1 = !r1; drop0 = 1'b0; drop1 = 1'b0;
    for (int k = 0; k < 40 && !(done0 && done1 && pending() == 0); k++) begin
      @(posedge clock); #1;
      if (drop0) begin p0_req = 1'b0; done0 = 1'b1; drop0 = 1'b0; end
      else if (p0_req && p0_gnt) drop0 = 1'b1;
      if (drop1) begin p1_req = 1'b0; done1 = 1'b1; drop1 = 1'b0; end
      else if (p1_req && p1_gnt) drop1 = 1'b1;
    end
    check("round_drained", pending() + int'(!done0) + int'(!done1), 0);
    p0_req = 1'b0; p1_req = 1'b0;
    gnt_q.delete(); wr_q.delete(); rd_q0.delete(); rd_q1.delete();
  endtask

  // Start one access on port p, then pull reset during its first active cycle.
  task automatic reset_during(input bit p, input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    int k;
    model_access(p, w, a, d);
    if (!w) begin
      // The aborted read never returns, so it has no read expectation.
      if (p) void'(rd_q1.pop_back()); else void'(rd_q0.pop_back());
    end
    @(posedge clock); #1;
    if (p) begin p1_req = 1'b1; p1_write = w; p1_addr = a; p1_wdata = d; end
    else   begin p0_req = 1'b1; p0_write = w; p0_addr = a; p0_wdata = d; end
    k = 0;
    while (!(p0_gnt || p1_gnt) && k < 10) begin
      @(posedge clock); #1;
      k++;
    end
    check("abort_gnt_seen", {30'd0, p1_gnt, p0_gnt}, p ? 2 : 1);
    @(negedge clock); #1;
    reset_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    ref_last = 1'b1; exp_rdata0 = '0; exp_rdata1 = '0;
    check("abort_ram_write", {31'd0, ram_write}, 0);
    check("abort_gnt", {30'd0, p1_gnt, p0_gnt}, 0);
    check("abort_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 0);
    check("abort_p0_rdata", p0_rdata, 0);
    check("abort_p1_rdata", p1_rdata, 0);
    repeat (4) @(posedge clock);
    #1;
    check("abort_drained", pending(), 0);
    gnt_q.delete(); wr_q.delete(); rd_q0.delete(); rd_q1.delete();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 9'd511;
      1:       return 9'd0;
      default: return 9'($urandom_range(1, 6));
    endcase
  endfunction

  initial begin
    logic [1:0]    r;
    logic [DW-1:0] v;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end

    // T1: reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 0);
    check("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 0);
    check("rst_ram_write", {31'd0, ram_write}, 0);
    check("rst_ram_address", {23'd0, ram_address}, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    reset_n = 1'b1;

    // T2: p0 write then read of address 0
    do_round(1, 0, 1, 0, 9'd0, 9'd0, 32'hAA, 32'h0);
    do_round(1, 0, 0, 0, 9'd0, 9'd0, 32'h0, 32'h0);
    // T3: addr 1 = 0x55, then both read at once (p0 wins)
    do_round(0, 1, 0, 1, 9'd0, 9'd1, 32'h0, 32'h55);
    do_round(1, 1, 0, 0, 9'd0, 9'd1, 32'h0, 32'h0);
    // T4: continuous contention, six accesses
    for (int i = 0; i < 3; i++)
      do_round(1, 1, 1'($urandom), 1'($urandom), rand_addr(), rand_addr(), $urandom, $urandom);
    // T5: p1 writes addr 1, p0 reads it; p1_rdata must not move
    do_round(0, 1, 0, 1, 9'd0, 9'd1, 32'h0, 32'h2A);
    do_round(1, 0, 0, 0, 9'd1, 9'd0, 32'h0, 32'h0);
    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      do_round(r[0], r[1], 1'($urandom), 1'($urandom), rand_addr(), rand_addr(),
               $urandom, $urandom);
    end
    // T6: known value at 511, read aborted by reset, then read 511 back
    do_round(1, 0, 1, 0, 9'd511, 9'd0, 32'hDEAD0511, 32'h0);
    reset_during(1'b0, 1'b0, 9'd5, 32'h0);
    do_round(1, 0, 0, 0, 9'd511, 9'd0, 32'h0, 32'h0);
    // Reset during WR: the write was committed at that edge
    reset_during(1'b1, 1'b1, 9'd9, 32'hC0FFEE09);
    do_round(1, 1, 0, 0, 9'd9, 9'd511, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
